// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the integer register-file writeback slice.
package rv_wb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per integer register plus a 3-way hazard lookup.
module wb_scoreboard
  import rv_wb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  logic [REG_AW-1:0]   set_rd_i,
  input  logic                clr_en_i,
  input  logic [REG_AW-1:0]   clr_rd_i,
  input  logic [REG_AW-1:0]   q_rs1_i,
  input  logic [REG_AW-1:0]   q_rs2_i,
  input  logic [REG_AW-1:0]   q_rd_i,
  input  logic                rs1_ign_i,
  input  logic                rs2_ign_i,
  output logic                hazard_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i) set_mask[set_rd_i] = 1'b1;
    if (clr_en_i) clr_mask[clr_rd_i] = 1'b1;
    // Set is applied after clear so a same-cycle reissue keeps the bit; x0 is never busy.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // busy_q[0] is constantly 0, which masks x0 in every lookup.
  assign hazard_o = (busy_q[q_rs1_i] & ~rs1_ign_i) |
                    (busy_q[q_rs2_i] & ~rs2_ign_i) |
                    busy_q[q_rd_i];
  assign busy_o   = busy_q;

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and long-latency writebacks onto the single register-file write port.
// Optional WB_BYPASS_EN exposes the buffered long-latency result to decode.
module reg_writeback_unit
  import rv_wb_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]     alu_data,
  output logic                alu_stall,
  input  logic                lu_issue,
  input  logic [REG_AW-1:0]   lu_issue_rd,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [REG_AW-1:0]   lu_rd,
  input  logic [XLEN-1:0]     lu_data,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [XLEN-1:0]     rf_wdata,
  input  logic [REG_AW-1:0]   q_rs1,
  input  logic [REG_AW-1:0]   q_rs2,
  input  logic [REG_AW-1:0]   q_rd,
`ifdef WB_BYPASS_EN
  output logic                byp_rs1_hit,
  output logic                byp_rs2_hit,
  output logic [XLEN-1:0]     byp_rs1_data,
  output logic [XLEN-1:0]     byp_rs2_data,
`endif
  output logic                hazard,
  output logic [NUM_REGS-1:0] busy_mask
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  wb_req_t           buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

  logic    starve_max, drain, alu_acc, lu_xfer, wr_fire;
  wb_req_t wr_req;
  logic    rs1_ign, rs2_ign;

  always_comb begin
    starve_max = (starve_q == CntW'(STARVE_LIMIT));
    drain      = buf_valid_q & (~alu_valid | starve_max);
    alu_stall  = alu_valid & buf_valid_q & starve_max;
    alu_acc    = alu_valid & ~alu_stall;
    // Held low through reset so upstream cannot hand over a result that would be discarded.
    lu_ready   = ~rst & (~buf_valid_q | drain);
    lu_xfer    = lu_valid & lu_ready;

    wr_fire = drain | alu_acc;
    wr_req  = drain ? buf_q : wb_req_t'{rd: alu_rd, data: alu_data};

    rf_we_d    = wr_fire & (wr_req.rd != '0);
    rf_waddr_d = wr_fire ? wr_req.rd : rf_waddr_q;
    rf_wdata_d = wr_fire ? wr_req.data : rf_wdata_q;

    buf_valid_d = (buf_valid_q & ~drain) | lu_xfer;
    buf_d       = lu_xfer ? wb_req_t'{rd: lu_rd, data: lu_data} : buf_q;

    starve_d = starve_q;
    if (drain) begin
      starve_d = '0;
    end else if (buf_valid_q && alu_valid && !starve_max) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      starve_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_BYPASS_EN
  assign byp_rs1_hit  = buf_valid_q & (q_rs1 != '0) & (buf_q.rd == q_rs1);
  assign byp_rs2_hit  = buf_valid_q & (q_rs2 != '0) & (buf_q.rd == q_rs2);
  assign byp_rs1_data = buf_q.data;
  assign byp_rs2_data = buf_q.data;
  assign rs1_ign      = byp_rs1_hit;
  assign rs2_ign      = byp_rs2_hit;
`else
  assign rs1_ign = 1'b0;
  assign rs2_ign = 1'b0;
`endif

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (lu_issue),
    .set_rd_i  (lu_issue_rd),
    .clr_en_i  (drain),
    .clr_rd_i  (buf_q.rd),
    .q_rs1_i   (q_rs1),
    .q_rs2_i   (q_rs2),
    .q_rd_i    (q_rd),
    .rs1_ign_i (rs1_ign),
    .rs2_ign_i (rs2_ign),
    .hazard_o  (hazard),
    .busy_o    (busy_mask)
  );

`ifndef SYNTHESIS
  // Decode's hazard check must keep an ALU op off a register the buffer is about to retire.
  a_no_same_rd : assert property (@(posedge clk) disable iff (rst)
    !(alu_valid && drain && alu_rd != '0 && alu_rd == buf_q.rd));
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed self-checking bench for reg_writeback_unit.
module tb_reg_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lu_issue;
  logic [4:0]  lu_issue_rd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        hazard;
  logic [31:0] busy_mask;
`ifdef WB_BYPASS_EN
  logic        byp_rs1_hit, byp_rs2_hit;
  logic [31:0] byp_rs1_data, byp_rs2_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_writeback_unit #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_stall   (alu_stall),
    .lu_issue    (lu_issue),
    .lu_issue_rd (lu_issue_rd),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_rd       (lu_rd),
    .lu_data     (lu_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .q_rs1       (q_rs1),
    .q_rs2       (q_rs2),
    .q_rd        (q_rd),
`ifdef WB_BYPASS_EN
    .byp_rs1_hit (byp_rs1_hit),
    .byp_rs2_hit (byp_rs2_hit),
    .byp_rs1_data(byp_rs1_data),
    .byp_rs2_data(byp_rs2_data),
`endif
    .hazard      (hazard),
    .busy_mask   (busy_mask)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] data);
    check_eq({tag, ".we"}, 32'(rf_we), 32'(we));
    if (we) begin
      check_eq({tag, ".waddr"}, 32'(rf_waddr), 32'(addr));
      check_eq({tag, ".wdata"}, rf_wdata, data);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lu_issue = 1'b0; lu_issue_rd = '0;
    lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;

    // Reset state
    #1;
    check_eq("rst.rf_we", 32'(rf_we), 32'd0);
    check_eq("rst.rf_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst.rf_wdata", rf_wdata, 32'd0);
    check_eq("rst.busy", busy_mask, 32'd0);
    check_eq("rst.lu_ready", 32'(lu_ready), 32'd0);
    check_eq("rst.alu_stall", 32'(alu_stall), 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    check_eq("rel.lu_ready", 32'(lu_ready), 32'd1);

    // 1: plain ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    check_eq("t1.stall", 32'(alu_stall), 32'd0);
    cyc();
    alu_valid = 1'b0;
    check_rf("t1.wr", 1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    check_rf("t1.once", 1'b0, 5'd0, 32'd0);

    // 2: issue, hazard, LU result retires
    lu_issue = 1'b1; lu_issue_rd = 5'd7;
    cyc();
    lu_issue = 1'b0;
    q_rs1 = 5'd7;
    #1;
    check_eq("t2.busy", busy_mask, 32'h0000_0080);
    check_eq("t2.haz_rs1", 32'(hazard), 32'd1);
    q_rs1 = 5'd0; q_rd = 5'd7;
    #1;
    check_eq("t2.haz_rd", 32'(hazard), 32'd1);
    q_rd = 5'd0; q_rs2 = 5'd6;
    #1;
    check_eq("t2.haz_none", 32'(hazard), 32'd0);
    q_rs2 = 5'd0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h12345678;
    #1;
    check_eq("t2.ready", 32'(lu_ready), 32'd1);
    cyc();
    lu_valid = 1'b0;
    #1;
    check_eq("t2.drain_ready", 32'(lu_ready), 32'd1);
    check_eq("t2.busy_pre", busy_mask, 32'h0000_0080);
    cyc();
    check_rf("t2.wr", 1'b1, 5'd7, 32'h12345678);
    check_eq("t2.busy_clr", busy_mask, 32'd0);

    // 3: starvation limit with ALU held busy
    lu_issue = 1'b1; lu_issue_rd = 5'd3;
    cyc();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'hA5A5A5A5;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
    #1;
    check_eq("t3.stall_a", 32'(alu_stall), 32'd0);
    cyc();
    lu_valid = 1'b0;
    check_rf("t3.wr_a", 1'b1, 5'd10, 32'h100);
    for (int i = 1; i <= 4; i++) begin
      alu_data = 32'h100 + 32'(i);
      #1;
      check_eq($sformatf("t3.stall_%0d", i), 32'(alu_stall), 32'd0);
      check_eq($sformatf("t3.full_ready_%0d", i), 32'(lu_ready), 32'd0);
      cyc();
      check_rf($sformatf("t3.wr_%0d", i), 1'b1, 5'd10, 32'h100 + 32'(i));
    end
    alu_data = 32'h200;
    #1;
    check_eq("t3.stall_hit", 32'(alu_stall), 32'd1);
    check_eq("t3.ready_drain", 32'(lu_ready), 32'd1);
    cyc();
    check_rf("t3.wr_buf", 1'b1, 5'd3, 32'hA5A5A5A5);
    check_eq("t3.busy_clr", busy_mask, 32'd0);
    check_eq("t3.stall_rel", 32'(alu_stall), 32'd0);
    cyc();
    alu_valid = 1'b0;
    check_rf("t3.wr_held", 1'b1, 5'd10, 32'h200);
    cyc();
    check_rf("t3.idle", 1'b0, 5'd0, 32'd0);

    // 4: x0 handling
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    check_eq("t4.stall", 32'(alu_stall), 32'd0);
    cyc();
    alu_valid = 1'b0;
    check_rf("t4.x0", 1'b0, 5'd0, 32'd0);
    lu_issue = 1'b1; lu_issue_rd = 5'd0;
    cyc();
    lu_issue = 1'b0;
    check_eq("t4.busy_x0", busy_mask, 32'd0);

    // 5: drain and reissue of the same rd in one cycle
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    cyc();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    cyc();
    lu_valid = 1'b0;
    lu_issue = 1'b1; lu_issue_rd = 5'd9;
    cyc();
    lu_issue = 1'b0;
    check_rf("t5.wr", 1'b1, 5'd9, 32'h99);
    check_eq("t5.busy_set_wins", busy_mask, 32'h0000_0200);
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h9A;
    cyc();
    lu_valid = 1'b0;
    cyc();
    check_rf("t5.wr2", 1'b1, 5'd9, 32'h9A);
    check_eq("t5.busy_clr", busy_mask, 32'd0);

    // 6: reset with a full buffer and a pending register
    lu_issue = 1'b1; lu_issue_rd = 5'd4;
    cyc();
    lu_issue = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 32'h44;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h55;
    cyc();
    lu_valid = 1'b0;
    check_eq("t6.busy_pre", busy_mask, 32'h0000_0010);
    check_eq("t6.full", 32'(lu_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_rf("t6.rst_rf", 1'b0, 5'd0, 32'd0);
    check_eq("t6.rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("t6.rst_wdata", rf_wdata, 32'd0);
    check_eq("t6.rst_busy", busy_mask, 32'd0);
    check_eq("t6.rst_ready", 32'(lu_ready), 32'd0);
    check_eq("t6.rst_stall", 32'(alu_stall), 32'd0);
    alu_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check_eq("t6.rel_ready", 32'(lu_ready), 32'd1);
    cyc();
    check_rf("t6.no_wr", 1'b0, 5'd0, 32'd0);
    check_eq("t6.busy_post", busy_mask, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
